adder_pipelined: RTL and testbench

- Parametrised, pipelined successor to the combinational ripple adders (adder_1/adder_n).
- Splits an N-bit add/subtract into STAGES registered carry-chain slices, so wide arithmetic closes timing at the cell-update clock of the game-of-life datapath.
- Uses a valid/ready handshake on both sides with global stall.
- Adds a subtract mode and a signed-overflow flag.

---
 rtl/adder_pipelined.sv | 113 +++++++++++
 tb/tb_adder_pipelined.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : adder_pipelined
// Brief    : N-bit add/subtract split into STAGES registered carry-chain
//            slices, valid/ready handshake on both sides, global stall.
// Revision : 1.0 - initial release
// ============================================================================
module adder_pipelined #(
   parameter int N      = 32,
   parameter int STAGES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         c_in,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         c_out,
   output logic         overflow
);

   localparam int CHUNK = N / ((STAGES >= 1) ? STAGES : 1);

   generate
      if (STAGES < 1 || STAGES > N || (N % ((STAGES >= 1) ? STAGES : 1)) != 0) begin : g_bad_params
         $error("adder_pipelined: STAGES must lie in 1..N and divide N");
      end
   endgenerate

   // r_x: low chunks already summed, high chunks still operand A.
   // r_y: operand B (pre-inverted for subtract); its low chunks go unused.
   logic [N-1:0] r_x [STAGES];
   logic [N-1:0] r_y [STAGES];
   logic         r_c [STAGES];
   logic         r_v [STAGES];
   logic         r_ovf;

   logic [N-1:0] w_xn [STAGES];
   logic [N-1:0] w_yn [STAGES];
   logic         w_cn [STAGES];
   logic         w_vn [STAGES];
   logic [N-1:0] w_sx;
   logic [N-1:0] w_sy;
   logic         w_sc;
   logic         w_sv;
   logic [CHUNK:0] w_add;
   logic         w_ovf;
   logic         w_adv;

   assign w_adv     = ~r_v[STAGES-1] | out_ready;
   assign in_ready  = w_adv;
   assign out_valid = r_v[STAGES-1];
   assign sum       = r_x[STAGES-1];
   assign c_out     = r_c[STAGES-1];
   assign overflow  = r_ovf;

   always_comb begin
      w_xn  = '{default: '0};
      w_yn  = '{default: '0};
      w_cn  = '{default: 1'b0};
      w_vn  = '{default: 1'b0};
      w_add = '0;
      w_ovf = 1'b0;
      w_sx  = a;
      w_sy  = sub ? ~b : b;
      w_sc  = sub | c_in;
      w_sv  = in_valid;
      for (int k = 0; k < STAGES; k++) begin
         w_add = {1'b0, w_sx[k*CHUNK +: CHUNK]} + {1'b0, w_sy[k*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, w_sc};
         w_xn[k] = w_sx;
         w_xn[k][k*CHUNK +: CHUNK] = w_add[CHUNK-1:0];
         w_yn[k] = w_sy;
         w_cn[k] = w_add[CHUNK];
         w_vn[k] = w_sv;
         // Carry into the MSB is recovered from the MSB sum bit and its operands.
         if (k == STAGES-1) begin
            w_ovf = w_add[CHUNK] ^ (w_add[CHUNK-1] ^ w_sx[N-1] ^ w_sy[N-1]);
         end
         w_sx = r_x[k];
         w_sy = r_y[k];
         w_sc = r_c[k];
         w_sv = r_v[k];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < STAGES; k++) begin
            r_x[k] <= '0;
            r_y[k] <= '0;
            r_c[k] <= 1'b0;
            r_v[k] <= 1'b0;
         end
         r_ovf <= 1'b0;
      end else if (w_adv) begin
         for (int k = 0; k < STAGES; k++) begin
            r_x[k] <= w_xn[k];
            r_y[k] <= w_yn[k];
            r_c[k] <= w_cn[k];
            r_v[k] <= w_vn[k];
         end
         r_ovf <= w_ovf;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_adder_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_pipelined
// Brief    : Scoreboard bench for adder_pipelined, N=8 with STAGES=4, 1 and 8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_pipelined;

   localparam int NI = 3;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic       sub;
      logic [7:0] sum;
      logic       co;
      logic       of;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic [NI-1:0]      t_iv, t_ordy, t_cin, t_sub, t_acc;
   logic [NI-1:0]      d_irdy, d_ov, d_co, d_of;
   logic [NI-1:0][7:0] t_a, t_b, d_sum;
   logic [9:0]         t_exp [NI];
   logic [9:0]         sbq [NI][$];
   vec_t               tbl [12];
   int                 n_vec, n_bad;

   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < NI; g++) begin : g_dut
         adder_pipelined #(.N(8), .STAGES(g == 0 ? 4 : (g == 1 ? 1 : 8))) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (t_iv[g]),
            .in_ready (d_irdy[g]),
            .a        (t_a[g]),
            .b        (t_b[g]),
            .c_in     (t_cin[g]),
            .sub      (t_sub[g]),
            .out_valid(d_ov[g]),
            .out_ready(t_ordy[g]),
            .sum      (d_sum[g]),
            .c_out    (d_co[g]),
            .overflow (d_of[g])
         );
      end
   endgenerate

   function automatic int stg(input int i);
      return (i == 0) ? 4 : ((i == 1) ? 1 : 8);
   endfunction

   // Reference: {overflow, c_out, sum}
   function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic cin, input logic sub);
      logic [7:0] bb;
      logic [8:0] t;
      logic       of;
      bb = sub ? ~b : b;
      t  = {1'b0, a} + {1'b0, bb} + {8'd0, (sub | cin)};
      of = (a[7] == bb[7]) && (t[7] != a[7]);
      return {of, t[8], t[7:0]};
   endfunction

   task automatic chk(input string nm, input int inst, input logic [31:0] got, input logic [31:0] req);
      n_vec++;
      if (got !== req) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %0h, required %0h", nm, inst, got, req);
      end
   endtask

   task automatic present(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub);
      t_a[i]   = a;
      t_b[i]   = b;
      t_cin[i] = cin;
      t_sub[i] = sub;
      t_iv[i]  = 1'b1;
      t_exp[i] = model(a, b, cin, sub);
   endtask

   task automatic cycle();
      logic [9:0] e;
      #1;
      for (int i = 0; i < NI; i++) begin
         t_acc[i] = t_iv[i] & d_irdy[i];
         if (d_ov[i] && t_ordy[i]) begin
            if (sbq[i].size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_result[%0d]: got %0h, required no output", i, d_sum[i]);
            end else begin
               e = sbq[i].pop_front();
               chk("result", i, {22'd0, d_of[i], d_co[i], d_sum[i]}, {22'd0, e});
            end
         end
         if (t_acc[i]) sbq[i].push_back(t_exp[i]);
      end
      @(posedge clk);
      #1;
   endtask

   function automatic bit sb_empty();
      for (int i = 0; i < NI; i++) if (sbq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drain(input int maxc);
      t_iv   = '0;
      t_ordy = '1;
      for (int c = 0; c < maxc; c++) begin
         if (sb_empty()) break;
         cycle();
      end
      for (int i = 0; i < NI; i++) chk("drain", i, sbq[i].size(), 0);
   endtask

   task automatic run_ops(input int nops, input bit rnd);
      int         left [NI];
      int         idx  [NI];
      bit         done;
      logic [7:0] bv;
      t_iv  = '0;
      t_acc = '0;
      for (int i = 0; i < NI; i++) begin
         left[i] = nops;
         idx[i]  = 0;
      end
      for (int cyc = 0; cyc < 8000; cyc++) begin
         done = 1'b1;
         for (int i = 0; i < NI; i++) begin
            if (!t_iv[i] || t_acc[i]) begin
               if (left[i] > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
                  if (rnd) begin
                     present(i, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
                  end else begin
                     bv = 8'(idx[i]) * 8'd37 + 8'd11;
                     present(i, 8'(idx[i]), bv, idx[i][8], idx[i][9]);
                  end
                  idx[i]++;
                  left[i]--;
               end else begin
                  t_iv[i] = 1'b0;
               end
            end
            t_ordy[i] = !rnd || ($urandom_range(0, 3) != 0);
            if (left[i] != 0 || t_iv[i] || sbq[i].size() != 0) done = 1'b0;
         end
         if (done) break;
         cycle();
      end
      for (int i = 0; i < NI; i++) chk("stream_done", i, sbq[i].size() + left[i], 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int         lat [NI];
      int         run, best, left, k;
      logic [9:0] held;
      bit         all;

      n_vec = 0;
      n_bad = 0;
      rst    = 1'b0;
      t_iv   = '0;
      t_ordy = '0;
      t_a    = '0;
      t_b    = '0;
      t_cin  = '0;
      t_sub  = '0;
      t_acc  = '0;
      for (int i = 0; i < NI; i++) t_exp[i] = '0;

      tbl[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[1]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
      tbl[2]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
      tbl[3]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      tbl[4]  = '{8'h3C, 8'h3C, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
      tbl[5]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
      tbl[6]  = '{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0};
      tbl[7]  = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
      tbl[8]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
      tbl[9]  = '{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[10] = '{8'h12, 8'h34, 1'b1, 1'b1, 8'hDE, 1'b0, 1'b0};
      tbl[11] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};

      // Reset held with downstream stalled: in_ready must still be high.
      repeat (3) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NI; i++) begin
            chk("rst_out_valid", i, d_ov[i], 0);
            chk("rst_sum", i, d_sum[i], 0);
            chk("rst_in_ready", i, d_irdy[i], 1);
         end
      end
      rst    = 1'b1;
      t_ordy = '1;
      repeat (2) cycle();
      for (int i = 0; i < NI; i++) chk("idle_out_valid", i, d_ov[i], 0);

      // Single op latency on every build.
      for (int i = 0; i < NI; i++) present(i, 8'hFF, 8'h01, 1'b0, 1'b0);
      cycle();
      t_iv = '0;
      for (int i = 0; i < NI; i++) lat[i] = -1;
      for (k = 0; k < 20; k++) begin
         all = 1'b1;
         for (int i = 0; i < NI; i++) begin
            if (lat[i] < 0 && d_ov[i]) lat[i] = k;
            if (lat[i] < 0) all = 1'b0;
         end
         if (all) break;
         cycle();
      end
      for (int i = 0; i < NI; i++) chk("latency", i, lat[i], stg(i) - 1);
      drain(30);

      // Table vectors back-to-back; output run must have no gaps.
      run  = 0;
      best = 0;
      for (int v = 0; v < 12; v++) begin
         t_a[0]   = tbl[v].a;
         t_b[0]   = tbl[v].b;
         t_cin[0] = tbl[v].cin;
         t_sub[0] = tbl[v].sub;
         t_exp[0] = {tbl[v].of, tbl[v].co, tbl[v].sum};
         t_iv[0]  = 1'b1;
         cycle();
         run  = d_ov[0] ? run + 1 : 0;
         best = (run > best) ? run : best;
      end
      t_iv[0] = 1'b0;
      for (int c = 0; c < 20 && sbq[0].size() != 0; c++) begin
         cycle();
         run  = d_ov[0] ? run + 1 : 0;
         best = (run > best) ? run : best;
      end
      chk("b2b_run", 0, best, 12);

      // Ten-op stream with a three-cycle downstream stall in the middle.
      left  = 10;
      t_acc = '0;
      held  = '0;
      for (int it = 0; it < 40; it++) begin
         if (!t_iv[0] || t_acc[0]) begin
            if (left > 0) begin
               present(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
               left--;
            end else begin
               t_iv[0] = 1'b0;
            end
         end
         t_ordy[0] = !(it >= 6 && it <= 8);
         if (it >= 6 && it <= 8) begin
            #1;
            chk("hold_in_ready", 0, d_irdy[0], 0);
            chk("hold_out_valid", 0, d_ov[0], 1);
            if (it == 6) held = {d_of[0], d_co[0], d_sum[0]};
            else chk("hold_result", 0, {d_of[0], d_co[0], d_sum[0]}, held);
         end
         if (left == 0 && !t_iv[0] && sbq[0].size() == 0) break;
         cycle();
      end
      chk("hold_drain", 0, sbq[0].size() + left, 0);

      // Reset asserted between edges with four ops in flight.
      t_ordy = '1;
      for (int it = 0; it < 4; it++) begin
         present(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
         cycle();
      end
      t_iv[0] = 1'b0;
      chk("pre_rst_valid", 0, d_ov[0], 1);
      rst = 1'b0;
      #1;
      chk("async_out_valid", 0, d_ov[0], 0);
      chk("async_sum", 0, d_sum[0], 0);
      chk("async_flags", 0, {d_of[0], d_co[0]}, 0);
      chk("async_in_ready", 0, d_irdy[0], 1);
      for (int i = 0; i < NI; i++) sbq[i].delete();
      @(posedge clk);
      #2;
      rst = 1'b1;
      present(0, 8'h10, 8'h20, 1'b0, 1'b0);
      t_exp[0] = 10'h030;
      cycle();
      t_iv[0] = 1'b0;
      for (k = 0; k < 20 && !d_ov[0]; k++) cycle();
      chk("rst_recover_latency", 0, k, 3);
      drain(30);

      // Deterministic sweep at full rate, then random handshake stream.
      run_ops(1024, 1'b0);
      run_ops(1000, 1'b1);
      drain(30);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
